// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, instruction} pairs.
// It uses valid/ready handshakes on both sides and a single-cycle flush.
module if_id_queue #(
    parameter int unsigned Depth = 4,
    parameter int unsigned PcW   = 64,
    parameter int unsigned InstW = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PcW-1:0]             in_pc_i,
    input  logic [InstW-1:0]           in_inst_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PcW-1:0]             out_pc_o,
    output logic [InstW-1:0]           out_inst_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PcW-1:0]   pc_mem_q   [Depth];
    logic [InstW-1:0] inst_mem_q [Depth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic full, empty, push, pop;

    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);

    // Ready drops while reset is held so fetch never sees a push accepted.
    assign in_ready_o  = !full && rst_ni;
    assign out_valid_o = !empty;
    assign count_o     = cnt_q;

    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        out_pc_o   = '0;
        out_inst_o = '0;
        if (!empty) begin
            out_pc_o   = pc_mem_q[rd_ptr_q];
            out_inst_o = inst_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= in_pc_i;
            inst_mem_q[wr_ptr_q] <= in_inst_i;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/drain, streaming, flush,
// full-with-pop and mid-operation reset, all with hand-computed expectations.
module tb_if_id_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int n_cmp;
    int n_bad;

    if_id_queue #(
        .Depth(4),
        .PcW  (64),
        .InstW(32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_pc_i    (in_pc),
        .in_inst_i  (in_inst),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_pc_o   (out_pc),
        .out_inst_o (out_inst),
        .count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [63:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h1000;
        in_inst   = 32'h0;
        out_ready = 1'b0;

        // Reset held for two edges while fetch offers data
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_count", count, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_pc", out_pc, 0);
            check_eq("rst_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check_eq("rel_in_ready", in_ready, 1);
        check_eq("rel_count", count, 0);

        // Fill
        for (int i = 0; i < 4; i++) begin
            push_one(64'(4 * i), 32'h00500093 + 32'(i));
            check_eq("fill_count", count, 64'(i + 1));
        end
        check_eq("full_in_ready", in_ready, 0);
        push_one(64'h10, 32'hdeadbeef);
        check_eq("fifth_count", count, 4);

        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", out_valid, 1);
            check_eq("drain_pc", out_pc, 64'(4 * i));
            check_eq("drain_inst", out_inst, 64'(32'h00500093 + 32'(i)));
            step();
        end
        out_ready = 1'b0;
        check_eq("drained_valid", out_valid, 0);
        check_eq("drained_count", count, 0);

        // Streaming through the pointer wrap
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc   = 64'h100 + 64'(4 * k);
            in_inst = 32'h1000 + 32'(k);
            if (k > 0) begin
                check_eq("stream_pc", out_pc, 64'h100 + 64'(4 * (k - 1)));
            end
            step();
            check_eq("stream_count", count, 1);
        end
        in_valid = 1'b0;
        check_eq("stream_last_pc", out_pc, 64'h124);
        step();
        out_ready = 1'b0;
        check_eq("stream_end_count", count, 0);

        // Flush with push and pop in the same cycle
        push_one(64'h300, 32'h1);
        push_one(64'h304, 32'h2);
        push_one(64'h308, 32'h3);
        check_eq("pre_flush_count", count, 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'h3fc;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("flush_count", count, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_out_pc", out_pc, 0);
        check_eq("flush_in_ready", in_ready, 1);
        push_one(64'h200, 32'h5);
        check_eq("post_flush_pc", out_pc, 64'h200);
        check_eq("post_flush_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("post_flush_empty", count, 0);

        // Full with simultaneous pop: pop only
        for (int i = 0; i < 4; i++) begin
            push_one(64'h400 + 64'(4 * i), 32'h40 + 32'(i));
        end
        in_valid  = 1'b1;
        in_pc     = 64'h500;
        out_ready = 1'b1;
        check_eq("fullpop_in_ready", in_ready, 0);
        step();
        in_valid = 1'b0;
        check_eq("fullpop_count", count, 3);
        check_eq("fullpop_ready_next", in_ready, 1);
        for (int i = 1; i < 4; i++) begin
            check_eq("fullpop_drain_pc", out_pc, 64'h400 + 64'(4 * i));
            step();
        end
        out_ready = 1'b0;
        check_eq("fullpop_end_count", count, 0);

        // Reset mid-operation while pushing
        push_one(64'h600, 32'h6);
        push_one(64'h604, 32'h7);
        check_eq("pre_rst_count", count, 2);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_pc    = 64'h700;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check_eq("midrst_count", count, 0);
        check_eq("midrst_valid", out_valid, 0);
        push_one(64'h800, 32'h8);
        push_one(64'h804, 32'h9);
        check_eq("midrst_head_pc", out_pc, 64'h800);
        check_eq("midrst_head_inst", out_inst, 64'h8);
        out_ready = 1'b1;
        step();
        check_eq("midrst_next_pc", out_pc, 64'h804);
        step();
        out_ready = 1'b0;
        check_eq("midrst_end_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched {PC, instruction} pairs in a circular FIFO with valid/ready handshakes on both sides, which decouples fetch from decode stalls. It also supports a single-cycle flush that discards all buffered instructions on a branch redirect or exception.

## Interface
Parameters:
- DEPTH, 4, number of entries; a power of two, at least 2
- PC_W, 64, PC width
- INST_W, 32, instruction width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low; clears the queue on any rising edge where reset=0
- flush  input  1  discards all entries; same-cycle push is dropped
- in_valid  input  1  fetch presents a valid pair
- in_ready  output  1  queue accepts a push this cycle
- in_pc  input  PC_W  PC of the fetched instruction
- in_inst  input  INST_W  fetched instruction word
- out_valid  output  1  head entry is available to decode
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  PC_W  PC of the head entry
- out_inst  output  INST_W  instruction of the head entry
- count  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: DEPTH-entry arrays for PC and instruction, plus write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits wide. Pointers wrap from DEPTH-1 to 0 by natural overflow.
- Occupancy register cnt, range 0..DEPTH. count = cnt.
- Full = (cnt == DEPTH). Empty = (cnt == 0).
- in_ready = !full && reset. It is combinational and does not depend on in_valid or out_ready.
- out_valid = !empty. It is combinational from cnt.
- Output data when not empty: out_pc and out_inst = mem[rd_ptr].
- Output data when empty: out_pc and out_inst are forced to 0.
- Push = in_valid && in_ready && !flush. On push, mem[wr_ptr] <= {in_pc, in_inst} and wr_ptr increments.
- Pop = out_valid && out_ready && !flush. On pop, rd_ptr increments.
- Count update:
  - push only: cnt+1
  - pop only: cnt-1
  - push and pop together: cnt unchanged, and both pointers advance
- Full with out_ready=1: in_ready stays 0 that cycle. The entry freed by the pop is not refilled until the next cycle; there is no pass-through.
- Empty with in_valid=1: the pushed entry becomes visible at the output on the next cycle. There is no combinational bypass.
- Flush: wr_ptr, rd_ptr and cnt all go to 0 at the next edge. Any push or pop in the flush cycle is ignored. Memory contents are not cleared.
- Priority, highest first: reset, then flush, then push/pop.
- Ignored inputs:
  - in_valid=1 while in_ready=0 is ignored; fetch must hold its data.
  - out_ready=1 while out_valid=0 is ignored.
- Reset has the same effect as flush. It may be applied mid-operation, and buffered entries are lost.

## Timing
- Reset values (after the first edge with reset=0):
  - cnt=0 and count=0
  - out_valid=0, out_pc=0, out_inst=0
  - in_ready=0 while reset=0; in_ready=1 on the first cycle after reset returns high
- Latency from push to visible at the output: 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < cnt < DEPTH.
- Flush asserted in cycle N: out_valid=0 from cycle N+1. in_ready=1 in cycle N+1.
- A transfer on either side occurs only on an edge where valid and ready are both 1 and flush=0.
- count and out_valid change only at clock edges. Outputs are glitch-free with respect to in_valid, out_ready and flush.

## Test plan
- Reset:
  - Stimulus: hold reset=0 for 2 cycles with in_valid=1, in_pc=0x1000; then release.
  - Required: count=0, out_valid=0, out_pc=0 throughout; in_ready=1 on the first cycle after release.
- Fill and drain:
  - Stimulus: with out_ready=0, push PCs 0x0, 0x4, 0x8, 0xC with instructions 0x00500093 through 0x00500096.
  - Required: count reaches 4, in_ready=0, and a fifth push of 0x10 is not accepted.
  - Then set out_ready=1. Required: pops in order 0x0, 0x4, 0x8, 0xC with matching instructions; out_valid=0 after the 4th pop.
- Streaming and wrap-around:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 10 cycles, PC incrementing by 4 from 0x100.
  - Required: count stays at 1 after the first cycle; out_pc sequence is 0x100..0x124 with no gaps or duplicates; the pointers wrap at least twice.
- Flush with simultaneous events:
  - Stimulus: with count=3, assert flush, in_valid=1 and out_ready=1 in the same cycle.
  - Required: next cycle count=0 and out_valid=0; the in_pc of that cycle never appears at the output.
  - Then push 0x200. Required: out_pc=0x200 one cycle later.
- Full with simultaneous pop:
  - Stimulus: with count=4, out_ready=1 and in_valid=1.
  - Required: one pop, no push, count=3; in_ready=1 the next cycle.
- Reset mid-operation:
  - Stimulus: with count=2, assert reset=0 for one edge while pushing.
  - Required: count=0 and out_valid=0. Subsequent pushes are read back starting from the first new PC.
